// File: rtl/serdes_pkg.sv
// Shared serdes definitions: framer states, default sync marker and word width.
// Word width grows to 9 bits (8 data + even parity) when DES_PARITY_EN is defined.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } des_state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

`ifdef DES_PARITY_EN
  localparam int WORD_BITS = 9;
`else
  localparam int WORD_BITS = 8;
`endif

  // Even parity: the transmitted parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/des_shift_in.sv
// Serial-in shift register and bit counter for the deserializer framer.
// Word boundary flags the cycle in which sr holds a complete word.
module des_shift_in
  import serdes_pkg::*;
(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 ser_in,
  input  logic                 align,
  output logic [WORD_BITS-1:0] sr,
  output logic                 boundary
);

  localparam logic [3:0] BCNT_MAX = 4'(WORD_BITS - 1);

  logic [WORD_BITS-1:0] sr_r;
  logic [3:0]           bcnt_r;

  // Shift MSB-first data in; align restarts counting at the first bit after a sync hit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sr_r   <= '0;
      bcnt_r <= 4'd0;
    end else begin
      sr_r <= {sr_r[WORD_BITS-2:0], ser_in};
      if (align) begin
        bcnt_r <= 4'd0;
      end else if (bcnt_r == BCNT_MAX) begin
        bcnt_r <= 4'd0;
      end else begin
        bcnt_r <= bcnt_r + 4'd1;
      end
    end
  end

  assign sr       = sr_r;
  assign boundary = (bcnt_r == BCNT_MAX);

endmodule

// File: rtl/des_frame_sync.sv
// Deserializer frame synchroniser: hunt/verify/locked alignment on a periodic sync word.
// Optional even parity per word when DES_PARITY_EN is defined; otherwise parity_err stays 0.
module des_frame_sync
  import serdes_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
  parameter int         FRAME_WORDS  = 4,
  parameter int         SYNC_CONFIRM = 2,
  parameter int         SYNC_LOSS    = 3
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       ser_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       parity_err
);

  localparam logic [7:0] WCNT_MAX = 8'(FRAME_WORDS);
  localparam logic [3:0] CONF_LIM = 4'(SYNC_CONFIRM);
  localparam logic [3:0] LOSS_LIM = 4'(SYNC_LOSS);

  des_state_e           state_r;
  logic [7:0]           wcnt_r;
  logic [3:0]           cnt_r;
  logic [7:0]           data_out_r;
  logic                 data_valid_r;
  logic                 locked_r;
  logic                 parity_err_r;

  logic [WORD_BITS-1:0] sr_s;
  logic                 boundary_s;
  logic                 align_s;
  logic [7:0]           data_s;
  logic                 par_ok_s;
  logic                 sync_hit_s;
  logic [7:0]           wcnt_nxt_s;
  logic [3:0]           cnt_inc_s;

  des_shift_in u_shift_in (
    .clk      (clk),
    .nreset   (nreset),
    .ser_in   (ser_in),
    .align    (align_s),
    .sr       (sr_s),
    .boundary (boundary_s)
  );

  // Sync detection and slot bookkeeping derived from the current shift register contents.
  always_comb begin
    data_s = sr_s[WORD_BITS-1 -: 8];
`ifdef DES_PARITY_EN
    par_ok_s = (even_parity(data_s) == sr_s[0]);
`else
    par_ok_s = 1'b1;
`endif
    sync_hit_s = (data_s == SYNC_WORD) && par_ok_s;
    align_s    = (state_r == ST_HUNT) && sync_hit_s;
    if (wcnt_r >= WCNT_MAX) begin
      wcnt_nxt_s = 8'd0;
    end else begin
      wcnt_nxt_s = wcnt_r + 8'd1;
    end
    cnt_inc_s = cnt_r + 4'd1;
  end

  // Lock FSM with registered outputs; locked follows the state register edge for edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r      <= ST_HUNT;
      wcnt_r       <= 8'd0;
      cnt_r        <= 4'd0;
      data_out_r   <= 8'd0;
      data_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      case (state_r)
        ST_HUNT: begin
          if (sync_hit_s) begin
            wcnt_r <= 8'd1;
            if (CONF_LIM <= 4'd1) begin
              state_r  <= ST_LOCKED;
              locked_r <= 1'b1;
              cnt_r    <= 4'd0;
            end else begin
              state_r <= ST_VERIFY;
              cnt_r   <= 4'd1;
            end
          end
        end
        ST_VERIFY: begin
          if (boundary_s) begin
            wcnt_r <= wcnt_nxt_s;
            if (wcnt_r == 8'd0) begin
              if (sync_hit_s && (cnt_inc_s >= CONF_LIM)) begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
                cnt_r    <= 4'd0;
              end else if (sync_hit_s) begin
                cnt_r <= cnt_inc_s;
              end else begin
                state_r <= ST_HUNT;
                cnt_r   <= 4'd0;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (boundary_s) begin
            wcnt_r <= wcnt_nxt_s;
            // Slot position alone decides data vs sync, so a data word equal to the marker is delivered.
            if (wcnt_r != 8'd0) begin
              data_out_r   <= data_s;
              data_valid_r <= 1'b1;
              parity_err_r <= ~par_ok_s;
            end else if (sync_hit_s) begin
              cnt_r <= 4'd0;
            end else if (cnt_inc_s >= LOSS_LIM) begin
              state_r  <= ST_HUNT;
              locked_r <= 1'b0;
              cnt_r    <= 4'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        default: begin
          state_r  <= ST_HUNT;
          locked_r <= 1'b0;
          cnt_r    <= 4'd0;
        end
      endcase
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign locked     = locked_r;
  assign parity_err = parity_err_r;

endmodule
